rpc_maint_timer_bank: RTL and testbench
=======================================

Name: rpc_maint_timer_bank

Overview:
Parametrised maintenance-command generator.
- Replaces a fixed starter/refresh/ZQ-cal timer trio with NUM_TIMERS identical periodic channels.
- Each channel tracks postponed commands in a credit counter.
- A round-robin arbiter merges all channels onto one valid/ready command port toward CMD_FSM.
- Sits between the config register block (which supplies the config ports) and the CMD_FSM arbiter.

Parameters:
NUM_TIMERS, 2, number of periodic channels (>=1)
CNT_WIDTH, 32, period/start-delay counter width
CMD_WIDTH, 19, width of the emitted command word
MAX_PENDING, 8, max postponed commands per channel (>=1)
PEND_WIDTH, $clog2(MAX_PENDING+1), derived, width of the pending count
ID_WIDTH, max(1,$clog2(NUM_TIMERS)), derived, width of the channel id

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, synchronous, active-low
init_completed_i  in  1  DRAM init done (level) from CMD_FSM
start_delay_i  in  CNT_WIDTH  cycles to wait after init before channels run
cfg_load_i  in  NUM_TIMERS  one-cycle per-channel config load strobe
cfg_i  in  NUM_TIMERS x timer_cfg_t  per-channel {enable, period, cmd}
cmd_valid_o  out  1  command available
cmd_ready_i  in  1  downstream accepts
cmd_o  out  CMD_WIDTH  command word
cmd_id_o  out  ID_WIDTH  issuing channel index
pending_o  out  NUM_TIMERS x PEND_WIDTH  per-channel credit count
overflow_o  out  NUM_TIMERS  sticky: a tick was lost at saturation
overflow_clr_i  in  1  clears all overflow_o bits

Behaviour:
- Reset: synchronous, active-low, sampled on clk_i rising edge.
  - Outputs after reset: cmd_valid_o=0, cmd_o=0, cmd_id_o=0, pending_o=0, overflow_o=0.
  - Internal: all channel configs disabled, round-robin pointer=0, FSM=IDLE.
  - Reset asserted mid-handshake drops the in-flight command with no further effect.
- Global FSM:
  - IDLE: leave when init_completed_i=1. Load delay counter with start_delay_i, go to DELAY. If start_delay_i=0, go directly to RUN.
  - DELAY: decrement each cycle; at 1, go to RUN next cycle. Total latency init->RUN = start_delay_i cycles.
  - RUN: terminal until reset. init_completed_i falling is ignored.
- Channel config:
  - cfg_load_i[k] registers cfg_i[k] in any FSM state.
  - In RUN, it also reloads the channel counter with the new period.
  - On entry to RUN, every enabled channel's counter is loaded with its period.
  - Loading enable=0, or period=0: channel stops ticking and its pending count clears to 0. If channel k is currently being presented, the presented transaction completes unchanged.
- Channel counter (RUN, enabled, period P>0):
  - Down-counter P..1. At 1: emit a tick and reload P. First tick occurs P cycles after RUN entry or after a load; period is exactly P cycles.
- Pending credit:
  - A tick increments pending. A handshake on that channel decrements it.
  - Tick and handshake in the same cycle on the same channel: count unchanged.
  - Tick when pending=MAX_PENDING: count stays, overflow_o[k] set. This applies even when a same-cycle handshake occurs on that channel.
  - overflow_clr_i clears overflow_o; a same-cycle set wins.
- Arbiter/output:
  - Output is registered. When cmd_valid_o=0 (or a handshake occurs this cycle), pick the next channel with pending>0, excluding the one consuming its last credit. Search round-robin starting at the channel after the last granted one.
  - Drive cmd_valid_o=1, cmd_o=cfg.cmd, cmd_id_o=k on the following cycle. Latency from first tick to cmd_valid_o is 1 cycle.
  - cmd_o/cmd_id_o stay stable while cmd_valid_o=1 && !cmd_ready_i. A config reload does not alter the held word.
  - Back-to-back handshakes are supported: one command per cycle when ready is held high.
  - Presenting a command does not consume credit; only the handshake does.
- pending_o reflects the registered counts.

Decomposition:
- Package rpc_maint_pkg:
  - timer_cfg_t packed struct {logic enable; logic [CNT_WIDTH-1:0] period; logic [CMD_WIDTH-1:0] cmd}, with package-level defaults CNT_WIDTH=32, CMD_WIDTH=19.
  - FSM enum maint_state_e {IDLE, DELAY, RUN}.
- Sub-module rpc_maint_timer_chan, instantiated NUM_TIMERS times: config register, period counter, pending/overflow logic.
- The bank top holds the global FSM, the round-robin arbiter and the output register.

Test Plan:
- Start delay: start_delay_i=10, ch0 {en=1, P=5}, init_completed_i rises at t0 -> RUN at t0+10, first ch0 tick at t0+15, cmd_valid_o=1 at t0+16 with cmd_id_o=0.
- Periodic, ready tied high: ch0 P=4 -> cmd_valid_o pulses every 4 cycles, pending_o[0] never exceeds 1.
- Saturation: ready=0, MAX_PENDING=8, P=3 -> pending_o[0] reaches 8 after 24 cycles, overflow_o[0]=1 at 27. Release ready -> exactly 8 handshakes drain pending to 0. overflow_clr_i clears the flag.
- Round-robin: ch0/ch1 both P=2 with ready=0 until both pending=3, then ready=1 -> cmd_id_o sequence 0,1,0,1,0,1 with no gaps; cmd_o held stable during ready=0 stalls.
- Reconfig/disable: ch1 pending=2 while presented, load {en=0} -> the presented command completes, then pending_o[1]=0 and no further ch1 commands. Reload ch0 P=7 mid-count -> next tick 7 cycles after the load.
- Reset mid-operation: rst_ni low for one cycle with cmd_valid_o=1 -> next cycle all outputs 0, FSM IDLE. Commands resume only after init_completed_i and the start delay.

Source files
------------

// File: rtl/rpc_maint_pkg.sv
// Shared types for the maintenance-command timer bank.
package rpc_maint_pkg;

   // Default field widths of the per-channel configuration word.
   localparam int DEF_CNT_WIDTH = 32;
   localparam int DEF_CMD_WIDTH = 19;

   typedef struct packed {
      logic                     enable;
      logic [DEF_CNT_WIDTH-1:0] period;
      logic [DEF_CMD_WIDTH-1:0] cmd;
   } timer_cfg_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DELAY = 2'd1,
      RUN   = 2'd2
   } maint_state_e;

   // A channel only ticks when it is enabled and has a non-zero period.
   function automatic logic cfg_active(timer_cfg_t c);
      return c.enable && (c.period != '0);
   endfunction

endpackage

// File: rtl/rpc_maint_timer_chan.sv
// One periodic maintenance channel: config register, period down-counter,
// postponed-command credit counter and sticky overflow flag.
module rpc_maint_timer_chan
   import rpc_maint_pkg::*;
#(
   parameter int CNT_WIDTH   = DEF_CNT_WIDTH,
   parameter int MAX_PENDING = 8,
   parameter int PEND_WIDTH  = $clog2(MAX_PENDING + 1)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     run,
   input  logic                     run_entry,
   input  logic                     load,
   input  timer_cfg_t               cfg_in,
   input  logic                     handshake,
   input  logic                     overflow_clr,
   output logic [DEF_CMD_WIDTH-1:0] cmd,
   output logic [PEND_WIDTH-1:0]    pending,
   output logic                     avail,
   output logic                     overflow
);

   localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = CNT_WIDTH'(1);
   localparam logic [PEND_WIDTH-1:0] PEND_ONE = PEND_WIDTH'(1);
   localparam logic [PEND_WIDTH-1:0] PEND_MAX = PEND_WIDTH'(MAX_PENDING);

   timer_cfg_t           cfg_q;
   logic [CNT_WIDTH-1:0] cnt_q;
   logic                 active;
   logic                 tick;
   logic                 clear_now;
   logic                 full;

   assign active    = cfg_active(cfg_q);
   assign tick      = run && active && (cnt_q == CNT_ONE);
   // Loading a stopped config drops all postponed credit immediately.
   assign clear_now = load && !cfg_active(cfg_in);
   assign full      = (pending == PEND_MAX);
   assign avail     = (pending != '0) && !clear_now;
   assign cmd       = cfg_q.cmd;

   // Config register, writable in any global state.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cfg_q <= '0;
      end else if (load) begin
         cfg_q <= cfg_in;
      end
   end

   // Period counter: restarts on RUN entry or a load while running, else counts P..1.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (run_entry || (run && load)) begin
         cnt_q <= load ? cfg_in.period : cfg_q.period;
      end else if (tick) begin
         cnt_q <= cfg_q.period;
      end else if (run && active) begin
         cnt_q <= cnt_q - CNT_ONE;
      end
   end

   // Credit counter: tick adds, handshake removes, both together cancel.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pending <= '0;
      end else if (clear_now) begin
         pending <= '0;
      end else if (tick) begin
         if (!full && !handshake) begin
            pending <= pending + PEND_ONE;
         end
      end else if (handshake && (pending != '0)) begin
         pending <= pending - PEND_ONE;
      end
   end

   // Sticky overflow: a tick lost at saturation; a same-cycle set beats the clear.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         overflow <= 1'b0;
      end else if (tick && full) begin
         overflow <= 1'b1;
      end else if (overflow_clr) begin
         overflow <= 1'b0;
      end
   end

endmodule

// File: rtl/rpc_maint_timer_bank.sv
// Bank of periodic maintenance channels merged onto one valid/ready port.
// Handshake: a command transfers on a cycle where cmd_valid_o && cmd_ready_i;
// while cmd_valid_o is high and ready is low, cmd_o/cmd_id_o are held.
module rpc_maint_timer_bank
   import rpc_maint_pkg::*;
#(
   parameter int NUM_TIMERS  = 2,
   parameter int CNT_WIDTH   = DEF_CNT_WIDTH,
   parameter int CMD_WIDTH   = DEF_CMD_WIDTH,
   parameter int MAX_PENDING = 8,
   parameter int PEND_WIDTH  = $clog2(MAX_PENDING + 1),
   parameter int ID_WIDTH    = (NUM_TIMERS > 1) ? $clog2(NUM_TIMERS) : 1
) (
   input  logic                                  clk_i,
   input  logic                                  rst_ni,
   input  logic                                  init_completed_i,
   input  logic [CNT_WIDTH-1:0]                  start_delay_i,
   input  logic [NUM_TIMERS-1:0]                 cfg_load_i,
   input  timer_cfg_t [NUM_TIMERS-1:0]           cfg_i,
   output logic                                  cmd_valid_o,
   input  logic                                  cmd_ready_i,
   output logic [CMD_WIDTH-1:0]                  cmd_o,
   output logic [ID_WIDTH-1:0]                   cmd_id_o,
   output logic [NUM_TIMERS-1:0][PEND_WIDTH-1:0] pending_o,
   output logic [NUM_TIMERS-1:0]                 overflow_o,
   input  logic                                  overflow_clr_i
);

   localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = CNT_WIDTH'(1);
   localparam logic [PEND_WIDTH-1:0] PEND_ONE = PEND_WIDTH'(1);
   localparam logic [ID_WIDTH-1:0]   ID_ONE   = ID_WIDTH'(1);
   localparam logic [ID_WIDTH-1:0]   ID_LAST  = ID_WIDTH'(NUM_TIMERS - 1);

   maint_state_e                          state_q;
   logic [CNT_WIDTH-1:0]                  delay_q;
   logic                                  go_run;
   logic                                  run;
   logic                                  hs;
   logic [NUM_TIMERS-1:0]                 hs_vec;
   logic [NUM_TIMERS-1:0]                 avail;
   logic [NUM_TIMERS-1:0]                 eligible;
   logic [NUM_TIMERS-1:0][CMD_WIDTH-1:0]  chan_cmd;
   logic [ID_WIDTH-1:0]                   rr_q;
   logic [ID_WIDTH-1:0]                   pick_id;
   logic                                  found;

   assign run = (state_q == RUN);
   assign hs  = cmd_valid_o && cmd_ready_i;

   // Leaving IDLE/DELAY this cycle; a delay of 0 or 1 goes straight to RUN.
   always_comb begin
      go_run = 1'b0;
      case (state_q)
         IDLE:    go_run = init_completed_i && (start_delay_i <= CNT_ONE);
         DELAY:   go_run = (delay_q == CNT_ONE);
         default: go_run = 1'b0;
      endcase
   end

   // Global FSM: IDLE -> DELAY -> RUN, RUN held until reset.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         delay_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (init_completed_i) begin
                  if (go_run) begin
                     state_q <= RUN;
                  end else begin
                     state_q <= DELAY;
                     delay_q <= start_delay_i - CNT_ONE;
                  end
               end
            end
            DELAY: begin
               if (go_run) begin
                  state_q <= RUN;
               end else begin
                  delay_q <= delay_q - CNT_ONE;
               end
            end
            RUN:     state_q <= RUN;
            default: state_q <= IDLE;
         endcase
      end
   end

   for (genvar k = 0; k < NUM_TIMERS; k++) begin : g_chan
      rpc_maint_timer_chan #(
         .CNT_WIDTH   (CNT_WIDTH),
         .MAX_PENDING (MAX_PENDING),
         .PEND_WIDTH  (PEND_WIDTH)
      ) u_chan (
         .clk          (clk_i),
         .rst_n        (rst_ni),
         .run          (run),
         .run_entry    (go_run),
         .load         (cfg_load_i[k]),
         .cfg_in       (cfg_i[k]),
         .handshake    (hs_vec[k]),
         .overflow_clr (overflow_clr_i),
         .cmd          (chan_cmd[k]),
         .pending      (pending_o[k]),
         .avail        (avail[k]),
         .overflow     (overflow_o[k])
      );
   end

   // Round-robin pick from the pointer; a channel spending its last credit is skipped.
   always_comb begin
      int idx;
      hs_vec   = '0;
      eligible = '0;
      found    = 1'b0;
      pick_id  = '0;
      idx      = 0;
      for (int k = 0; k < NUM_TIMERS; k++) begin
         hs_vec[k]   = hs && (cmd_id_o == ID_WIDTH'(k));
         eligible[k] = avail[k] && !(hs_vec[k] && (pending_o[k] == PEND_ONE));
      end
      for (int i = 0; i < NUM_TIMERS; i++) begin
         idx = int'(rr_q) + i;
         if (idx >= NUM_TIMERS) begin
            idx = idx - NUM_TIMERS;
         end
         if (!found && eligible[idx]) begin
            found   = 1'b1;
            pick_id = ID_WIDTH'(idx);
         end
      end
   end

   // Output register: reload when empty or on a handshake, otherwise hold.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         cmd_valid_o <= 1'b0;
         cmd_o       <= '0;
         cmd_id_o    <= '0;
         rr_q        <= '0;
      end else if (!cmd_valid_o || hs) begin
         cmd_valid_o <= found;
         if (found) begin
            cmd_o    <= chan_cmd[pick_id];
            cmd_id_o <= pick_id;
            rr_q     <= (pick_id == ID_LAST) ? '0 : pick_id + ID_ONE;
         end
      end
   end

endmodule

// File: tb/tb_rpc_maint_timer_bank.sv
// Randomized bench for rpc_maint_timer_bank against a schedule-based model.
module tb_rpc_maint_timer_bank;
   import rpc_maint_pkg::*;

   localparam int NT   = 3;
   localparam int MAXP = 8;
   localparam int PW   = 4;
   localparam int IW   = 2;

   // clock / reset / DUT signals
   logic                  clk = 1'b0;
   logic                  rst_n;
   logic                  init;
   logic [31:0]           start_delay;
   logic [NT-1:0]         cfg_load;
   timer_cfg_t [NT-1:0]   cfg;
   logic                  valid;
   logic                  ready;
   logic [18:0]           cmd;
   logic [IW-1:0]         cmd_id;
   logic [NT-1:0][PW-1:0] pending;
   logic [NT-1:0]         overflow;
   logic                  ovf_clr;

   always #5 clk = ~clk;

   rpc_maint_timer_bank #(
      .NUM_TIMERS  (NT),
      .MAX_PENDING (MAXP)
   ) dut (
      .clk_i            (clk),
      .rst_ni           (rst_n),
      .init_completed_i (init),
      .start_delay_i    (start_delay),
      .cfg_load_i       (cfg_load),
      .cfg_i            (cfg),
      .cmd_valid_o      (valid),
      .cmd_ready_i      (ready),
      .cmd_o            (cmd),
      .cmd_id_o         (cmd_id),
      .pending_o        (pending),
      .overflow_o       (overflow),
      .overflow_clr_i   (ovf_clr)
   );

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;

   // reference model: state visible during cycle cyc
   int          m_phase;     // 0 idle, 1 waiting for run_at, 2 running
   int          m_run_at;
   bit          m_en   [NT];
   int          m_per  [NT];
   logic [18:0] m_ccmd [NT];
   int          m_nt   [NT]; // cycle at which the next tick shows in pending, -1 none
   int          m_pend [NT];
   bit          m_ovf  [NT];
   bit          m_valid;
   logic [18:0] m_cmd;
   int          m_id;
   int          m_ptr;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
   endtask

   task automatic model_update();
      int nn;
      bit hs;
      bit tick [NT];
      bit clr  [NT];
      int np   [NT];
      bit nov  [NT];
      bit found;
      int pick;
      int sd;
      nn = cyc + 1;
      if (!rst_n) begin
         m_phase = 0; m_run_at = 0; m_valid = 0; m_cmd = '0; m_id = 0; m_ptr = 0;
         for (int k = 0; k < NT; k++) begin
            m_en[k] = 0; m_per[k] = 0; m_ccmd[k] = '0; m_nt[k] = -1; m_pend[k] = 0; m_ovf[k] = 0;
         end
         return;
      end
      hs = m_valid && ready;
      for (int k = 0; k < NT; k++) begin
         tick[k] = (m_phase == 2) && (m_nt[k] == nn);
         clr[k]  = cfg_load[k] && !(cfg[k].enable && cfg[k].period != 0);
         np[k]   = m_pend[k];
         nov[k]  = m_ovf[k];
         if (tick[k] && m_pend[k] == MAXP) nov[k] = 1;
         else if (ovf_clr) nov[k] = 0;
         if (clr[k]) np[k] = 0;
         else if (tick[k]) begin
            if (m_pend[k] < MAXP && !(hs && m_id == k)) np[k] = m_pend[k] + 1;
         end else if (hs && m_id == k && m_pend[k] > 0) np[k] = m_pend[k] - 1;
      end
      if (!m_valid || hs) begin
         found = 0;
         pick  = 0;
         for (int i = 0; i < NT; i++) begin
            int j;
            j = (m_ptr + i) % NT;
            if (!found && m_pend[j] > 0 && !clr[j] && !(hs && m_id == j && m_pend[j] == 1)) begin
               found = 1;
               pick  = j;
            end
         end
         m_valid = found;
         if (found) begin
            m_cmd = m_ccmd[pick];
            m_id  = pick;
            m_ptr = (pick + 1) % NT;
         end
      end
      for (int k = 0; k < NT; k++) begin
         if (tick[k]) m_nt[k] = m_nt[k] + m_per[k];
         if (cfg_load[k]) begin
            m_en[k]   = cfg[k].enable;
            m_per[k]  = int'(cfg[k].period);
            m_ccmd[k] = cfg[k].cmd;
            if (m_phase == 2) m_nt[k] = (m_en[k] && m_per[k] > 0) ? nn + m_per[k] : -1;
         end
         m_pend[k] = np[k];
         m_ovf[k]  = nov[k];
      end
      if (m_phase == 0 && init) begin
         sd = int'(start_delay);
         m_run_at = cyc + ((sd > 1) ? sd : 1);
         m_phase  = 1;
      end
      if (m_phase == 1 && m_run_at == nn) begin
         m_phase = 2;
         for (int k = 0; k < NT; k++)
            m_nt[k] = (m_en[k] && m_per[k] > 0) ? nn + m_per[k] : -1;
      end
   endtask

   task automatic compare_all();
      check("cmd_valid", valid, m_valid);
      check("cmd", cmd, m_cmd);
      check("cmd_id", cmd_id, m_id);
      for (int k = 0; k < NT; k++) begin
         check($sformatf("pending[%0d]", k), pending[k], m_pend[k]);
         check($sformatf("overflow[%0d]", k), overflow[k], m_ovf[k]);
      end
   endtask

   // one clock: DUT and model advance on the same edge, compare after it
   task automatic step();
      @(posedge clk);
      model_update();
      cyc++;
      #1;
      compare_all();
   endtask

   task automatic do_reset(input int cycles);
      rst_n = 1'b0;
      for (int i = 0; i < cycles; i++) step();
      rst_n = 1'b1;
   endtask

   function automatic timer_cfg_t make_cfg(input bit en, input int per, input logic [18:0] c);
      timer_cfg_t t;
      t.enable = en;
      t.period = 32'(per);
      t.cmd    = c;
      return t;
   endfunction

   function automatic timer_cfg_t rand_cfg();
      return make_cfg($urandom_range(0, 9) != 0,
                      ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 9)),
                      19'($urandom));
   endfunction

   initial begin
      int t0;
      int r;
      int rates [4];
      rates = '{0, 30, 70, 100};
      rst_n = 1'b0; init = 1'b0; start_delay = '0; cfg_load = '0; cfg = '0;
      ready = 1'b0; ovf_clr = 1'b0;

      // reset state
      do_reset(2);
      check("reset_valid", valid, 1'b0);
      check("reset_pending0", pending[0], 0);

      // start delay 10, ch0 period 5: first valid 16 cycles after init
      cfg_load = 3'b001;
      cfg[0]   = make_cfg(1'b1, 5, 19'h1a5a5);
      step();
      cfg_load = '0;
      start_delay = 32'd10;
      init = 1'b1;
      t0 = cyc;
      while (!valid && (cyc - t0) < 40) step();
      check("start_latency", cyc - t0, 16);
      check("start_id", cmd_id, 0);
      check("start_cmd", cmd, 19'h1a5a5);
      ready = 1'b1;
      for (int i = 0; i < 30; i++) step();

      // saturation: period 3, ready low, no start delay
      ready = 1'b0; init = 1'b0;
      do_reset(1);
      cfg_load = 3'b001;
      cfg[0]   = make_cfg(1'b1, 3, 19'h00c3);
      start_delay = '0;
      init = 1'b1;
      t0 = cyc;
      step();
      cfg_load = '0;
      r = t0 + 1;
      while (cyc < r + 24) step();
      check("sat_pending", pending[0], MAXP);
      while (cyc < r + 26) step();
      check("sat_no_overflow", overflow[0], 1'b0);
      step();
      check("sat_overflow", overflow[0], 1'b1);
      ovf_clr = 1'b1;
      step();
      ovf_clr = 1'b0;
      check("ovf_cleared", overflow[0], 1'b0);
      ready = 1'b1;
      for (int i = 0; i < 40; i++) step();

      // randomized segments, each opened by a mid-operation reset
      for (int seg = 0; seg < 14; seg++) begin
         int rate;
         int len;
         int init_at;
         rate    = rates[$urandom_range(0, 3)];
         len     = $urandom_range(150, 350);
         init_at = $urandom_range(0, 5);
         init    = 1'($urandom_range(0, 1));
         do_reset(1);
         init        = 1'b0;
         start_delay = 32'($urandom_range(0, 12));
         for (int c = 0; c < len; c++) begin
            if (c == init_at) init = 1'b1;
            else if (c > init_at + 30 && $urandom_range(0, 19) == 0) init = ~init;
            for (int k = 0; k < NT; k++) begin
               cfg_load[k] = (c == 0) || ($urandom_range(0, 99) < 3);
               cfg[k]      = rand_cfg();
            end
            ready   = ($urandom_range(0, 99) < rate);
            ovf_clr = ($urandom_range(0, 99) < 5);
            step();
         end
         cfg_load = '0;
         ovf_clr  = 1'b0;
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
